ex_muldiv: RTL and testbench

Iterative RV32M multiply/divide unit in the EX stage. It takes operands and funct3 from the ID/EX pipeline register outputs and returns a DATA_WIDTH result to the EX result mux. While an operation is in progress it drives a combinational stall, which the hazard logic uses to hold the ID/EX register enable and freeze the upstream stages. It uses one shift-add multiplier and one restoring divider, each doing one bit per cycle.

---
 rtl/muldiv_pkg.sv | 25 ++
 rtl/ex_muldiv_div_core.sv | 56 +++++
 rtl/ex_muldiv.sv | 228 ++++++++++++++++++++++
 tb/tb_ex_muldiv.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants for the RV32M multiply/divide unit.
//   - funct3 encodings for the eight M-extension operations
//   - FSM state encoding used by ex_muldiv
//   - M-extension opcode/funct7 constants, shared with the decoder
package muldiv_pkg;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  localparam logic [6:0] OPCODE_M  = 7'b0110011;
  localparam logic [6:0] FUNCT7_M  = 7'b0000001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/ex_muldiv_div_core.sv
// ex_muldiv_div_core: restoring-divide iteration, one quotient bit per step.
// Operates on unsigned magnitudes; sign fix-up is done by the caller.
// Ports:
//   clk, i_rst_n     clock, async active-low reset
//   i_load           capture dividend/divisor, clear the partial remainder
//   i_step           perform one iteration
//   i_dividend       dividend magnitude
//   i_divisor        divisor magnitude
//   o_quot_next      quotient after the step in progress (combinational)
//   o_rem_next       remainder after the step in progress (combinational)
module ex_muldiv_div_core #(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_load,
  input  logic                  i_step,
  input  logic [DATA_WIDTH-1:0] i_dividend,
  input  logic [DATA_WIDTH-1:0] i_divisor,
  output logic [DATA_WIDTH-1:0] o_quot_next,
  output logic [DATA_WIDTH-1:0] o_rem_next
);

  localparam int W = DATA_WIDTH;

  logic [W-1:0] r_rem;
  logic [W-1:0] r_quot;
  logic [W-1:0] r_divisor;
  logic [W:0]   w_shift;
  logic [W:0]   w_diff;
  logic         w_ge;

  // r_quot starts as the dividend and shifts out its MSB into the
  // partial remainder while quotient bits shift in from the bottom.
  assign w_shift     = {r_rem, r_quot[W-1]};
  assign w_diff      = w_shift - {1'b0, r_divisor};
  assign w_ge        = ~w_diff[W];
  assign o_rem_next  = w_ge ? w_diff[W-1:0] : w_shift[W-1:0];
  assign o_quot_next = {r_quot[W-2:0], w_ge};

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rem     <= '0;
      r_quot    <= '0;
      r_divisor <= '0;
    end else if (i_load) begin
      r_rem     <= '0;
      r_quot    <= i_dividend;
      r_divisor <= i_divisor;
    end else if (i_step) begin
      r_rem     <= o_rem_next;
      r_quot    <= o_quot_next;
    end
  end

endmodule

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit for the EX stage.
// Shift-add multiplier and restoring divider, one bit per cycle.
// Configuration macro: MULDIV_DIV_EN (defined: divider present; undefined:
// divide/remainder ops complete in one cycle with a zero result).
// Ports:
//   clk          rising-edge clock
//   i_rst_n      async active-low reset
//   i_start      valid M-extension instruction in EX
//   i_funct3     operation select
//   i_rs1_data   operand A
//   i_rs2_data   operand B
//   i_flush      abort current operation
//   o_busy       stall request (combinational)
//   o_done       one-cycle result-valid pulse
//   o_result     result, held until the next completion
//
// state | meaning
// IDLE  | waiting for i_start; division special cases resolved here
// CALC  | iterating, DATA_WIDTH cycles
// DONE  | o_done pulse, pipeline advances; i_start ignored
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  i_rst_n,
  input  logic                  i_start,
  input  logic [2:0]            i_funct3,
  input  logic [DATA_WIDTH-1:0] i_rs1_data,
  input  logic [DATA_WIDTH-1:0] i_rs2_data,
  input  logic                  i_flush,
  output logic                  o_busy,
  output logic                  o_done,
  output logic [DATA_WIDTH-1:0] o_result
);

  localparam int W  = DATA_WIDTH;
  localparam int CW = $clog2(DATA_WIDTH) + 1;

  state_t          r_state;
  state_t          w_state_next;
  logic [CW-1:0]   r_cnt;
  logic [2:0]      r_funct3;
  logic            r_neg;
  logic [2*W-1:0]  r_mcand;
  logic [2*W-1:0]  r_prod;
  logic [W-1:0]    r_mplier;
  logic            r_done;
  logic [W-1:0]    r_result;

  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_a_neg;
  logic            w_b_neg;
  logic [W-1:0]    w_a_mag;
  logic [W-1:0]    w_b_mag;
  logic            w_special;
  logic [W-1:0]    w_special_result;
  logic            w_accept;
  logic            w_take_special;
  logic            w_finish;
  logic            w_busy;
  logic            w_calc;
  logic [2*W-1:0]  w_prod_next;
  logic [2*W-1:0]  w_prod_signed;
  logic [W-1:0]    w_mul_result;
  logic [W-1:0]    w_calc_result;

  // MUL low half is sign-agnostic; treating it as signed keeps the mux simple.
  assign w_a_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                      (i_funct3 == F3_MULHSU) || (i_funct3 == F3_DIV) ||
                      (i_funct3 == F3_REM);
  assign w_b_signed = (i_funct3 == F3_MUL) || (i_funct3 == F3_MULH) ||
                      (i_funct3 == F3_DIV) || (i_funct3 == F3_REM);
  assign w_a_neg    = w_a_signed & i_rs1_data[W-1];
  assign w_b_neg    = w_b_signed & i_rs2_data[W-1];
  assign w_a_mag    = w_a_neg ? -i_rs1_data : i_rs1_data;
  assign w_b_mag    = w_b_neg ? -i_rs2_data : i_rs2_data;

`ifdef MULDIV_DIV_EN
  logic            r_rem_neg;
  logic            w_div_zero;
  logic            w_ovf;
  logic [W-1:0]    w_quot_next;
  logic [W-1:0]    w_rem_next;

  assign w_div_zero = (i_rs2_data == '0);
  assign w_ovf      = ((i_funct3 == F3_DIV) || (i_funct3 == F3_REM)) &&
                      (i_rs1_data == {1'b1, {(W-1){1'b0}}}) &&
                      (i_rs2_data == '1);
  assign w_special  = i_funct3[2] & (w_div_zero | w_ovf);

  // funct3[1] selects remainder over quotient.
  always_comb begin
    w_special_result = '0;
    if (w_div_zero)
      w_special_result = i_funct3[1] ? i_rs1_data : '1;
    else
      w_special_result = i_funct3[1] ? '0 : i_rs1_data;
  end

  ex_muldiv_div_core #(
    .DATA_WIDTH (W)
  ) u_div_core (
    .clk         (clk),
    .i_rst_n     (i_rst_n),
    .i_load      (w_accept),
    .i_step      (w_calc),
    .i_dividend  (w_a_mag),
    .i_divisor   (w_b_mag),
    .o_quot_next (w_quot_next),
    .o_rem_next  (w_rem_next)
  );

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_rem_neg <= 1'b0;
    else if (w_accept)
      r_rem_neg <= w_a_neg;
  end

  assign w_calc_result = !r_funct3[2] ? w_mul_result :
                         r_funct3[1]  ? (r_rem_neg ? -w_rem_next : w_rem_next) :
                                        (r_neg ? -w_quot_next : w_quot_next);
`else
  // Without the divider every divide/remainder op finishes in IDLE with 0.
  assign w_special        = i_funct3[2];
  assign w_special_result = '0;
  assign w_calc_result    = w_mul_result;
`endif

  assign w_calc = (r_state == CALC);

  always_comb begin
    w_state_next   = r_state;
    w_busy         = 1'b0;
    w_accept       = 1'b0;
    w_take_special = 1'b0;
    w_finish       = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (i_start && !i_flush) begin
          if (w_special) begin
            w_state_next   = DONE;
            w_take_special = 1'b1;
          end else begin
            w_state_next = CALC;
            w_accept     = 1'b1;
            w_busy       = 1'b1;
          end
        end
      end
      CALC: begin
        w_busy = 1'b1;
        if (i_flush) begin
          w_state_next = IDLE;
        end else if (r_cnt == '0) begin
          w_state_next = DONE;
          w_finish     = 1'b1;
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase
  end

  // Gated by reset so the stall drops immediately even with i_start held.
  assign o_busy = w_busy & i_rst_n;

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_state <= IDLE;
    else
      r_state <= w_state_next;
  end

  assign w_prod_next   = r_prod + (r_mplier[0] ? r_mcand : '0);
  assign w_prod_signed = r_neg ? -w_prod_next : w_prod_next;
  assign w_mul_result  = (r_funct3 == F3_MUL) ? w_prod_signed[W-1:0]
                                              : w_prod_signed[2*W-1:W];

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt    <= '0;
      r_funct3 <= '0;
      r_neg    <= 1'b0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_prod   <= '0;
    end else if (w_accept) begin
      r_cnt    <= CW'(W - 1);
      r_funct3 <= i_funct3;
      r_neg    <= w_a_neg ^ w_b_neg;
      r_mcand  <= {{W{1'b0}}, w_a_mag};
      r_mplier <= w_b_mag;
      r_prod   <= '0;
    end else if (w_calc) begin
      r_cnt    <= r_cnt - 1'b1;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_prod   <= w_prod_next;
    end
  end

  // Final iteration result is taken straight from the step logic so the
  // value lands in r_result on the same edge that enters DONE.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_done   <= 1'b0;
      r_result <= '0;
    end else begin
      r_done <= w_take_special | w_finish;
      if (w_take_special)
        r_result <= w_special_result;
      else if (w_finish)
        r_result <= w_calc_result;
    end
  end

  assign o_done   = r_done;
  assign o_result = r_result;

endmodule

// File: tb/tb_ex_muldiv.sv
module tb_ex_muldiv;

  localparam int W = 32;

  logic          clk;
  logic          i_rst_n;
  logic          i_start;
  logic [2:0]    i_funct3;
  logic [W-1:0]  i_rs1_data;
  logic [W-1:0]  i_rs2_data;
  logic          i_flush;
  logic          o_busy;
  logic          o_done;
  logic [W-1:0]  o_result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [W-1:0] last_res;

  ex_muldiv #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .i_rst_n    (i_rst_n),
    .i_start    (i_start),
    .i_funct3   (i_funct3),
    .i_rs1_data (i_rs1_data),
    .i_rs2_data (i_rs2_data),
    .i_flush    (i_flush),
    .o_busy     (o_busy),
    .o_done     (o_done),
    .o_result   (o_result)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chkb(input string tag, input logic obs, input logic exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Reference model: RV32M semantics via wide integer arithmetic.
  function automatic logic [W-1:0] ref_result(input logic [2:0] f3,
                                               input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    longint sa, sb, ub, q;
    logic [63:0] p;
    logic ovf;
    sa  = longint'($signed(a));
    sb  = longint'($signed(b));
    ub  = longint'({32'b0, b});
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
`ifndef MULDIV_DIV_EN
    if (f3[2]) return '0;
`endif
    case (f3)
      3'd0: begin p = sa * sb; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        q = sa / sb; return q[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        q = sa % sb; return q[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  function automatic int ref_lat(input logic [2:0] f3, input logic [W-1:0] a,
                                 input logic [W-1:0] b);
`ifdef MULDIV_DIV_EN
    if (f3[2] && (b == 0)) return 1;
    if ((f3 == 3'd4 || f3 == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return W + 1;
`else
    return f3[2] ? 1 : W + 1;
`endif
  endfunction

  // Issues one op at the next negedge (cycle 0) and follows it to o_done.
  // i_start stays high through DONE, as the instruction is still in EX.
  task automatic do_op(input logic [2:0] f3, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp,
                       input string tag);
    int lat;
    lat = ref_lat(f3, a, b);
    @(negedge clk);
    i_start = 1'b1; i_funct3 = f3; i_rs1_data = a; i_rs2_data = b;
    #1;
    chkb({tag, " busy c0"}, o_busy, lat != 1);
    for (int k = 1; k <= lat; k++) begin
      @(negedge clk);
      chkb({tag, " done"}, o_done, k == lat);
      if (k < lat) chkb({tag, " busy"}, o_busy, 1'b1);
    end
    chkb({tag, " busy at done"}, o_busy, 1'b0);
    chk({tag, " result"}, o_result, exp);
    last_res = exp;
  endtask

  initial begin
    logic [2:0]   f3;
    logic [W-1:0] a, b;
    int mode;

    i_rst_n = 1'b0; i_start = 1'b0; i_funct3 = '0;
    i_rs1_data = '0; i_rs2_data = '0; i_flush = 1'b0;
    last_res = '0;
    repeat (2) @(negedge clk);
    chkb("reset busy", o_busy, 1'b0);
    chkb("reset done", o_done, 1'b0);
    chk("reset result", o_result, '0);
    i_rst_n = 1'b1;

    // Directed cases, issued back to back.
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, "MUL 7*-3");
    do_op(3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, "MULH min*min");
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, "MULHU max*max");
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, "MULHSU -1*max");
    do_op(3'd0, 32'd3, 32'd3, 32'd9, "MUL 3*3");
`ifdef MULDIV_DIV_EN
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, "DIV -7/2");
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, "REM -7/2");
    do_op(3'd5, 32'd100, 32'd7, 32'd14, "DIVU 100/7");
    do_op(3'd7, 32'd100, 32'd7, 32'd2, "REMU 100/7");
    do_op(3'd5, 32'd5, 32'd0, 32'hFFFF_FFFF, "DIVU 5/0");
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, "DIV ovf");
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, "REM ovf");
`else
    do_op(3'd4, 32'd9, 32'd3, 32'h0, "DIV 9/3 nodiv");
    do_op(3'd7, 32'd100, 32'd7, 32'h0, "REMU nodiv");
`endif
    do_op(3'd0, 32'd1234, 32'd5678, 32'd7006652, "MUL after div");

    // Flush in cycle 10 of a MUL.
    @(negedge clk);
    i_start = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd11; i_rs2_data = 32'd13;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      chkb("flush pre busy", o_busy, 1'b1);
    end
    i_flush = 1'b1;
    @(negedge clk);
    i_flush = 1'b0; i_start = 1'b0;
    #1;
    chkb("flush busy", o_busy, 1'b0);
    chkb("flush done", o_done, 1'b0);
    chk("flush result", o_result, last_res);
    for (int k = 0; k < 25; k++) begin
      @(negedge clk);
      chkb("flush no done", o_done, 1'b0);
    end
    chk("flush result held", o_result, last_res);

    // Flush wins over start in IDLE.
    @(negedge clk);
    i_start = 1'b1; i_flush = 1'b1; i_funct3 = 3'd0;
    #1;
    chkb("start+flush busy", o_busy, 1'b0);
    @(negedge clk);
    i_start = 1'b0; i_flush = 1'b0;
    #1;
    chkb("start+flush not accepted", o_busy, 1'b0);
    chkb("start+flush no done", o_done, 1'b0);

    // Randomized ops with biased operands to hit special cases.
    for (int n = 0; n < 30; n++) begin
      f3   = 3'($urandom_range(0, 7));
      mode = $urandom_range(0, 5);
      a    = $urandom;
      b    = $urandom;
      if (mode == 0) b = '0;
      else if (mode == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
      else if (mode == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
      do_op(f3, a, b, ref_result(f3, a, b), "RAND");
    end

    // Asynchronous reset mid-operation.
    @(negedge clk);
`ifdef MULDIV_DIV_EN
    i_start = 1'b1; i_funct3 = 3'd4; i_rs1_data = 32'd100; i_rs2_data = 32'd7;
`else
    i_start = 1'b1; i_funct3 = 3'd0; i_rs1_data = 32'd3; i_rs2_data = 32'd5;
`endif
    for (int k = 1; k <= 20; k++) @(negedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    chkb("async rst busy", o_busy, 1'b0);
    chkb("async rst done", o_done, 1'b0);
    chk("async rst result", o_result, '0);
    @(negedge clk);
    i_start = 1'b0;
    i_rst_n = 1'b1;
    #1;
    chkb("post rst busy", o_busy, 1'b0);
    do_op(3'd0, 32'd3, 32'd3, 32'd9, "MUL after rst");

    @(negedge clk);
    i_start = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
